// File: rtl/sde_intr_pkg.sv
// ---------------------------------------------------------------------------
// sde_intr_pkg: shared constants for the SDE interrupt controller.
//   - Register word indices (address bits [4:2]) for the AXI4-Lite map.
//   - AXI response encoding.
//   - Per-channel sensitivity encodings for the MODE register.
//   - strbBitMask: expands a 4-bit byte strobe into a 32-bit bit mask.
// ---------------------------------------------------------------------------
package sde_intr_pkg;

  // Word index of each register, compared against addr[4:2].
  localparam logic [2:0] ADDR_GIE  = 3'd0;
  localparam logic [2:0] ADDR_IER  = 3'd1;
  localparam logic [2:0] ADDR_ISR  = 3'd2;
  localparam logic [2:0] ADDR_IAR  = 3'd3;
  localparam logic [2:0] ADDR_IPR  = 3'd4;
  localparam logic [2:0] ADDR_MODE = 3'd5;
  localparam logic [2:0] ADDR_RAW  = 3'd6;
  localparam logic [2:0] ADDR_RSVD = 3'd7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  function automatic logic [31:0] strbBitMask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sde_intr_sync.sv
// ---------------------------------------------------------------------------
// sde_intr_sync: vector synchroniser plus rising-edge detector.
//   clk      in   sampling clock
//   rstN     in   asynchronous active-low reset
//   asyncIn  in   WIDTH asynchronous inputs
//   sync     out  inputs after STAGES flops
//   rise     out  sync & ~(sync delayed one cycle)
// ---------------------------------------------------------------------------
module sde_intr_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stageQ [STAGES];
  logic [WIDTH-1:0] syncDlyQ;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int s = 0; s < STAGES; s++) begin
        stageQ[s] <= '0;
      end
      syncDlyQ <= '0;
    end else begin
      stageQ[0] <= asyncIn;
      for (int s = 1; s < STAGES; s++) begin
        stageQ[s] <= stageQ[s-1];
      end
      syncDlyQ <= stageQ[STAGES-1];
    end
  end

  assign sync = stageQ[STAGES-1];
  assign rise = sync & ~syncDlyQ;

endmodule

// File: rtl/sde_intr_ctrl.sv
// ---------------------------------------------------------------------------
// sde_intr_ctrl: AXI4-Lite interrupt controller for the SDE trigger IP.
//   s_axi_aclk / s_axi_aresetn  clock, asynchronous active-low reset
//   intr_in                     NUM_INTR asynchronous sources
//   s_axi_aw* / s_axi_w* / s_axi_b*  write channel (single outstanding)
//   s_axi_ar* / s_axi_r*             read channel (single outstanding)
//   irq                         registered interrupt request
// Registers: GIE, IER, ISR (sticky), IAR (W1C), IPR, MODE, RAW.
// ---------------------------------------------------------------------------
module sde_intr_ctrl
  import sde_intr_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_INTR           = 8,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned IRQ_ACTIVE_STATE   = 1,
  parameter int unsigned IRQ_PULSE          = 0
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [NUM_INTR-1:0]             intr_in,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            irq
);

  localparam int unsigned N = NUM_INTR;
  localparam logic IrqOn = (IRQ_ACTIVE_STATE != 0);
  localparam logic PulseMode = (IRQ_PULSE != 0);

  // ---------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------
  logic [N-1:0] syncVec;
  logic [N-1:0] riseVec;

  sde_intr_sync #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) uSync (
    .clk     (s_axi_aclk),
    .rstN    (s_axi_aresetn),
    .asyncIn (intr_in),
    .sync    (syncVec),
    .rise    (riseVec)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                wrReadyQ, wrReadyD;
  logic                bvalidQ, bvalidD;
  logic                arreadyQ, arreadyD;
  logic                rvalidQ, rvalidD;
  logic [31:0]         rdataQ, rdataD;
  logic                gieQ, gieD;
  logic [N-1:0]        ierQ, ierD;
  logic [N-1:0]        isrQ, isrD;
  logic [N-1:0]        modeQ, modeD;
  logic                anyQ;
  logic                irqQ, irqD;

  logic                wrHs, rdHs;
  logic [2:0]          wrIdx, rdIdx;
  logic [31:0]         wrEn;
  logic [N-1:0]        ackMask;
  logic [N-1:0]        setEvt;
  logic [31:0]         rdMux;
  logic                anyNow;

  assign wrIdx = s_axi_awaddr[4:2];
  assign rdIdx = s_axi_araddr[4:2];
  assign wrEn  = strbBitMask(s_axi_wstrb);

  // Ready is only raised while both valids are held, so the handshake is the ready cycle.
  assign wrHs = wrReadyQ & s_axi_awvalid & s_axi_wvalid;
  assign rdHs = arreadyQ & s_axi_arvalid;

  // ---------------------------------------------------------------------
  // AXI channel next state
  // ---------------------------------------------------------------------
  always_comb begin
    // ~wrReadyQ keeps ready to a single-cycle pulse per transaction
    wrReadyD = s_axi_awvalid & s_axi_wvalid & ~bvalidQ & ~wrReadyQ;
    bvalidD  = bvalidQ;
    if (wrHs) begin
      bvalidD = 1'b1;
    end else if (s_axi_bready) begin
      bvalidD = 1'b0;
    end
  end

  always_comb begin
    arreadyD = s_axi_arvalid & ~rvalidQ & ~arreadyQ;
    rvalidD  = rvalidQ;
    rdataD   = rdataQ;
    if (rdHs) begin
      rvalidD = 1'b1;
      rdataD  = rdMux;
    end else if (s_axi_rready) begin
      rvalidD = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Register writes and status update
  // ---------------------------------------------------------------------
  always_comb begin
    gieD    = gieQ;
    ierD    = ierQ;
    modeD   = modeQ;
    ackMask = '0;
    if (wrHs) begin
      case (wrIdx)
        ADDR_GIE: begin
          if (s_axi_wstrb[0]) gieD = s_axi_wdata[0];
        end
        ADDR_IER: begin
          ierD = (ierQ & ~wrEn[N-1:0]) | (s_axi_wdata[N-1:0] & wrEn[N-1:0]);
        end
        ADDR_IAR: begin
          ackMask = s_axi_wdata[N-1:0] & wrEn[N-1:0];
        end
        ADDR_MODE: begin
          modeD = (modeQ & ~wrEn[N-1:0]) | (s_axi_wdata[N-1:0] & wrEn[N-1:0]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    setEvt = '0;
    for (int i = 0; i < int'(N); i++) begin
      setEvt[i] = (modeQ[i] == MODE_LEVEL) ? syncVec[i] : riseVec[i];
    end
    // Set is ORed in after the clear so a coincident event wins over the ack.
    isrD = (isrQ & ~ackMask) | setEvt;
  end

  // ---------------------------------------------------------------------
  // Read mux (unimplemented bits and registers read 0)
  // ---------------------------------------------------------------------
  always_comb begin
    rdMux = '0;
    case (rdIdx)
      ADDR_GIE:  rdMux[0]     = gieQ;
      ADDR_IER:  rdMux[N-1:0] = ierQ;
      ADDR_ISR:  rdMux[N-1:0] = isrQ;
      ADDR_IPR:  rdMux[N-1:0] = isrQ & ierQ;
      ADDR_MODE: rdMux[N-1:0] = modeQ;
      ADDR_RAW:  rdMux[N-1:0] = syncVec;
      default:   rdMux        = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // irq generation
  // ---------------------------------------------------------------------
  always_comb begin
    logic active;
    anyNow = gieQ & (|(isrQ & ierQ));
    active = PulseMode ? (anyNow & ~anyQ) : anyNow;
    irqD   = IrqOn ? active : ~active;
  end

  // ---------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wrReadyQ <= 1'b0;
      bvalidQ  <= 1'b0;
      arreadyQ <= 1'b0;
      rvalidQ  <= 1'b0;
      rdataQ   <= '0;
    end else begin
      wrReadyQ <= wrReadyD;
      bvalidQ  <= bvalidD;
      arreadyQ <= arreadyD;
      rvalidQ  <= rvalidD;
      rdataQ   <= rdataD;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      gieQ  <= 1'b0;
      ierQ  <= '0;
      isrQ  <= '0;
      modeQ <= '0;
      anyQ  <= 1'b0;
      irqQ  <= ~IrqOn;
    end else begin
      gieQ  <= gieD;
      ierQ  <= ierD;
      isrQ  <= isrD;
      modeQ <= modeD;
      anyQ  <= anyNow;
      irqQ  <= irqD;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign s_axi_awready = wrReadyQ;
  assign s_axi_wready  = wrReadyQ;
  assign s_axi_bvalid  = bvalidQ;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arreadyQ;
  assign s_axi_rvalid  = rvalidQ;
  assign s_axi_rdata   = rdataQ;
  assign s_axi_rresp   = RESP_OKAY;
  assign irq           = irqQ;

  // Protection, byte-offset and out-of-range data bits are don't-care.
  logic unusedSink;
  assign unusedSink = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                        s_axi_wdata, wrEn};

endmodule
